// File: rtl/edge_rasterizer.sv
// rtl/edge_rasterizer.sv - bounding-box edge-function rasterizer with incremental edge update
module edge_rasterizer #(
  parameter int COORD_WIDTH   = 16,
  parameter int SCREEN_X_SIZE = 800,
  parameter int SCREEN_Y_SIZE = 600
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic signed [COORD_WIDTH-1:0]   bound_coefs [3][2],
  input  logic signed [2*COORD_WIDTH-1:0] bound_const [3],
  input  logic        [COORD_WIDTH-1:0]   bbox_min [2],
  input  logic        [COORD_WIDTH-1:0]   bbox_max [2],
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic        [COORD_WIDTH-1:0]   pix_x,
  output logic        [COORD_WIDTH-1:0]   pix_y,
  output logic                            busy,
  output logic                            done
);

  localparam int CW = COORD_WIDTH;
  localparam int AW = 2 * COORD_WIDTH + 2;
  localparam logic [CW-1:0] X_LIM = CW'(SCREEN_X_SIZE - 1);
  localparam logic [CW-1:0] Y_LIM = CW'(SCREEN_Y_SIZE - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  state_t                 state;
  logic signed [CW-1:0]   a_r [3];
  logic signed [CW-1:0]   b_r [3];
  logic signed [2*CW-1:0] c_r [3];
  logic [CW-1:0]          x_min, y_min, x_max, y_max;
  logic signed [AW-1:0]   e_acc [3];
  logic signed [AW-1:0]   row_e [3];

  logic signed [AW-1:0]   setup_e [3];
  logic signed [AW-1:0]   a_ext [3];
  logic signed [AW-1:0]   b_ext [3];
  logic                   all_ge, all_le, covered, advance, box_empty;

  // Sign-extend coefficients, evaluate edges at the box corner, and classify the current position
  always_comb begin
    all_ge = 1'b1;
    all_le = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_ext[i]   = $signed({{(AW-CW){a_r[i][CW-1]}}, a_r[i]});
      b_ext[i]   = $signed({{(AW-CW){b_r[i][CW-1]}}, b_r[i]});
      setup_e[i] = a_ext[i] * $signed({{(AW-CW){1'b0}}, x_min})
                 + b_ext[i] * $signed({{(AW-CW){1'b0}}, y_min})
                 + $signed({{(AW-2*CW){c_r[i][2*CW-1]}}, c_r[i]});
      if (e_acc[i][AW-1])
        all_ge = 1'b0;
      if (!e_acc[i][AW-1] && (e_acc[i] != '0))
        all_le = 1'b0;
    end
    covered   = all_ge || all_le;
    advance   = !covered || pix_ready;
    box_empty = (x_min > x_max) || (y_min > y_max);
    pix_valid = (state == SCAN) && covered;
  end

  // Control FSM: latch the triangle, set up edges once, then walk the box in raster order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pix_x <= '0;
      pix_y <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      x_min <= '0;
      y_min <= '0;
      x_max <= '0;
      y_max <= '0;
      for (int i = 0; i < 3; i++) begin
        a_r[i]   <= '0;
        b_r[i]   <= '0;
        c_r[i]   <= '0;
        e_acc[i] <= '0;
        row_e[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < 3; i++) begin
              a_r[i] <= bound_coefs[i][0];
              b_r[i] <= bound_coefs[i][1];
              c_r[i] <= bound_const[i];
            end
            x_min <= bbox_min[0];
            y_min <= bbox_min[1];
            x_max <= (bbox_max[0] > X_LIM) ? X_LIM : bbox_max[0];
            y_max <= (bbox_max[1] > Y_LIM) ? Y_LIM : bbox_max[1];
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          for (int i = 0; i < 3; i++) begin
            e_acc[i] <= setup_e[i];
            row_e[i] <= setup_e[i];
          end
          pix_x <= x_min;
          pix_y <= y_min;
          if (box_empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (advance) begin
            if (pix_x == x_max) begin
              if (pix_y == y_max) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                pix_x <= x_min;
                pix_y <= pix_y + ONE;
                for (int i = 0; i < 3; i++) begin
                  row_e[i] <= row_e[i] + b_ext[i];
                  e_acc[i] <= row_e[i] + b_ext[i];
                end
              end
            end else begin
              pix_x <= pix_x + ONE;
              for (int i = 0; i < 3; i++)
                e_acc[i] <= e_acc[i] + a_ext[i];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_rasterizer.sv
// tb/tb_edge_rasterizer.sv - randomized self-checking bench for edge_rasterizer
module tb_edge_rasterizer;

  localparam int CW = 16;
  localparam int SX = 800;
  localparam int SY = 600;

  logic                   clk;
  logic                   reset_n;
  logic                   start;
  logic signed [CW-1:0]   bc [3][2];
  logic signed [2*CW-1:0] cc [3];
  logic        [CW-1:0]   bmin [2];
  logic        [CW-1:0]   bmax [2];
  logic                   pix_valid;
  logic                   pix_ready;
  logic        [CW-1:0]   pix_x;
  logic        [CW-1:0]   pix_y;
  logic                   busy;
  logic                   done;

  int checks;
  int errors;

  edge_rasterizer #(.COORD_WIDTH(CW), .SCREEN_X_SIZE(SX), .SCREEN_Y_SIZE(SY)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bound_coefs(bc),
    .bound_const(cc),
    .bbox_min   (bmin),
    .bbox_max   (bmax),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_tri(input int a0, input int a1, input int a2,
                         input int b0, input int b1, input int b2,
                         input int c0, input int c1, input int c2,
                         input int x0, input int y0, input int x1, input int y1);
    bc[0][0] = CW'(a0); bc[1][0] = CW'(a1); bc[2][0] = CW'(a2);
    bc[0][1] = CW'(b0); bc[1][1] = CW'(b1); bc[2][1] = CW'(b2);
    cc[0] = 32'(c0); cc[1] = 32'(c1); cc[2] = 32'(c2);
    bmin[0] = CW'(x0); bmin[1] = CW'(y0);
    bmax[0] = CW'(x1); bmax[1] = CW'(y1);
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready
  // abort_at: reset while pixel number abort_at (0-based) is presented; -1 for none
  // poke: pulse start in the middle of the scan
  task automatic run_tri(input string name, input int mode, input int abort_at, input bit poke);
    int ex[$];
    int ey[$];
    int xm, ym, w, h, total, n, acc, done_n, limit, px, py;
    bit pv, pr, r;
    longint e [3];
    bit pos, neg;
    xm = (int'(bmax[0]) > SX - 1) ? SX - 1 : int'(bmax[0]);
    ym = (int'(bmax[1]) > SY - 1) ? SY - 1 : int'(bmax[1]);
    for (int y = int'(bmin[1]); y <= ym; y++) begin
      for (int x = int'(bmin[0]); x <= xm; x++) begin
        pos = 1'b1;
        neg = 1'b1;
        for (int i = 0; i < 3; i++) begin
          e[i] = longint'(bc[i][0]) * x + longint'(bc[i][1]) * y + longint'(cc[i]);
          if (e[i] < 0) pos = 1'b0;
          if (e[i] > 0) neg = 1'b0;
        end
        if (pos || neg) begin
          ex.push_back(x);
          ey.push_back(y);
        end
      end
    end
    w = (xm >= int'(bmin[0])) ? xm - int'(bmin[0]) + 1 : 0;
    h = (ym >= int'(bmin[1])) ? ym - int'(bmin[1]) + 1 : 0;
    total = ex.size();
    limit = 8 * w * h + 20;
    @(negedge clk);
    start = 1'b1;
    n = 0; acc = 0; done_n = 0;
    pv = 1'b0; pr = 1'b0; px = 0; py = 0;
    while (done_n == 0 && n < limit) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (poke) begin
        if (n == 6) start = 1'b1;
        else if (n == 7) start = 1'b0;
      end
      if (n >= 2 && done == 1'b0) check({name, " busy"}, busy, 1);
      if (pv && !pr) begin
        check({name, " stall_valid"}, pix_valid, 1);
        check({name, " stall_x"}, pix_x, px);
        check({name, " stall_y"}, pix_y, py);
      end
      case (mode)
        0: r = 1'b1;
        1: r = ((n - 1) % 4 == 0) || ((n - 1) % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pix_ready = r;
      if (abort_at >= 0 && pix_valid && acc == abort_at) begin
        reset_n = 1'b0;
        #1;
        check({name, " abort_valid"}, pix_valid, 0);
        check({name, " abort_busy"}, busy, 0);
        check({name, " abort_done"}, done, 0);
        repeat (3) begin
          @(negedge clk);
          check({name, " abort_nodone"}, done, 0);
          check({name, " abort_novalid"}, pix_valid, 0);
        end
        reset_n = 1'b1;
        start = 1'b0;
        return;
      end
      if (pix_valid && r) begin
        if (ex.size() == 0) begin
          check({name, " extra_pixel"}, 1, 0);
        end else begin
          check({name, " pix_x"}, pix_x, ex.pop_front());
          check({name, " pix_y"}, pix_y, ey.pop_front());
        end
        acc++;
      end
      if (done) done_n = n;
      pv = pix_valid; pr = r; px = int'(pix_x); py = int'(pix_y);
    end
    if (done_n == 0) check({name, " timeout"}, 0, 1);
    check({name, " pixel_count"}, acc, total);
    if (mode == 0) check({name, " done_latency"}, done_n, w * h + 2);
    @(negedge clk);
    check({name, " done_pulse"}, done, 0);
    check({name, " busy_after"}, busy, 0);
    pix_ready = 1'b0;
  endtask

  initial begin
    int a [3];
    int b [3];
    int c [3];
    int x0, y0, x1, y1;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    start = 1'b0;
    pix_ready = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset pix_valid", pix_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pix_x", pix_x, 0);
    check("reset pix_y", pix_y, 0);
    reset_n = 1'b1;
    @(negedge clk);

    set_tri(0, -4, 4, 4, -4, 0, 0, 16, 0, 0, 0, 4, 4);
    run_tri("ccw", 0, -1, 1'b0);
    set_tri(0, 4, -4, -4, 4, 0, 0, -16, 0, 0, 0, 4, 4);
    run_tri("cw", 0, -1, 1'b0);
    set_tri(0, -4, 4, 4, -4, 0, 0, 16, 0, 0, 0, 4, 4);
    run_tri("stall", 1, -1, 1'b0);
    set_tri(0, -4, 4, 4, -4, 0, 0, 16, 0, 5, 5, 4, 5);
    run_tri("empty", 0, -1, 1'b0);
    set_tri(0, 0, 0, 0, 0, 0, 1, 1, 1, 790, 590, 900, 700);
    run_tri("clamp", 0, -1, 1'b0);
    set_tri(0, 0, 0, 0, 0, 0, 1, 1, 1, 800, 10, 810, 12);
    run_tri("offscreen", 0, -1, 1'b0);
    set_tri(0, -4, 4, 4, -4, 0, 0, 16, 0, 0, 0, 4, 4);
    run_tri("abort", 0, 6, 1'b0);
    run_tri("restart", 0, -1, 1'b1);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 3; i++) begin
        a[i] = int'($urandom_range(0, 60)) - 30;
        b[i] = int'($urandom_range(0, 60)) - 30;
        c[i] = int'($urandom_range(0, 4000)) - 2000;
      end
      if ($urandom_range(0, 3) == 0) x0 = 790 + int'($urandom_range(0, 15));
      else x0 = int'($urandom_range(0, 780));
      y0 = int'($urandom_range(0, 595));
      x1 = x0 + int'($urandom_range(0, 9));
      y1 = y0 + int'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0 && x0 > 0) x1 = x0 - 1;
      set_tri(a[0], a[1], a[2], b[0], b[1], b[2], c[0], c[1], c[2], x0, y0, x1, y1);
      run_tri($sformatf("rand%0d", t), int'($urandom_range(0, 2)), -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_rasterizer.md
Name: edge_rasterizer

Overview:
- Consumes the three edge equations produced by the per-triangle vertex stage: bound_coefs and bound_const, with E_i(x,y) = a_i*x + b_i*y + c_i.
- Walks a bounding box in raster order and emits the covered pixel coordinates on a valid/ready stream toward the fragment stage.
- Edge values are updated incrementally, using adds only, after a single setup multiply phase.

Parameters:
- COORD_WIDTH, 16, width of coordinates and of a_i, b_i (two's complement).
- SCREEN_X_SIZE, 800, horizontal resolution; x_max clamps to SCREEN_X_SIZE-1.
- SCREEN_Y_SIZE, 600, vertical resolution; y_max clamps to SCREEN_Y_SIZE-1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  one-cycle request. Accepted only in IDLE.
- bound_coefs  in  [3][2] x COORD_WIDTH  signed. [i][0]=a_i, [i][1]=b_i.
- bound_const  in  [3] x 2*COORD_WIDTH  signed c_i.
- bbox_min  in  [2] x COORD_WIDTH  unsigned {x,y} lower corner.
- bbox_max  in  [2] x COORD_WIDTH  unsigned {x,y} upper corner.
- pix_valid  out  1  covered pixel available.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  COORD_WIDTH  pixel x.
- pix_y  out  COORD_WIDTH  pixel y.
- busy  out  1  high from the edge after start is accepted until the DONE state is left.
- done  out  1  one-cycle pulse at end of triangle.

Behaviour:
- States: IDLE, SETUP, SCAN, DONE.
  - IDLE->SETUP on start: latch all inputs; clamp the max corner to the screen.
  - SETUP->SCAN, or SETUP->DONE if the clamped box is empty (x_min>x_max or y_min>y_max).
  - SCAN->DONE after the last position is consumed.
  - DONE->IDLE unconditionally.
- Reset values: state=IDLE, pix_valid=0, pix_x=0, pix_y=0, busy=0, done=0, all accumulators 0.
- SETUP (1 cycle) computes, per edge, E_i(x_min,y_min) with multiplies. This value loads both row_E_i and E_i.
- Accumulators are signed, 2*COORD_WIDTH+2 bits. Operands are sign-extended and there is no saturation.
- covered = (E_0>=0 and E_1>=0 and E_2>=0) or (E_0<=0 and E_1<=0 and E_2<=0). Both windings are accepted.
- Degenerate triangle (all a_i, b_i, c_i zero): every box position is covered. This is intentional; upstream culls it.
- SCAN evaluates one position per cycle at (pix_x, pix_y), which are registers.
  - pix_valid = (state==SCAN) and covered. It is combinational from registers only; there is no path from pix_ready to pix_valid.
- Advance rule: the position advances when (not covered) or pix_ready.
  - When covered and pix_ready=0, pix_valid, pix_x, pix_y and E_i hold stable (AXI-style; no retraction).
- Step within a row: pix_x+1; E_i += a_i.
- At pix_x==x_max: pix_x=x_min, pix_y+1, row_E_i += b_i, E_i = row_E_i + b_i.
- At (x_max,y_max), advancing goes to DONE. done=1 for exactly the DONE cycle; busy=0 again in the following IDLE cycle.
- Latency: start sampled at edge T; SETUP after T; first position is presented after edge T+1.
  - With pix_ready=1 constant, a WxH box takes W*H SCAN cycles.
- start while busy is ignored and not queued. Inputs may change freely once start has been accepted.
- Asynchronous reset mid-SCAN returns to IDLE immediately: pix_valid=0, no done pulse. The partial triangle is lost.
- Box coordinates equal to the clamp limit are legal. A box fully off-screen (x_min>=SCREEN_X_SIZE) is empty.

Test Plan:
1. CCW triangle (0,0),(4,0),(0,4): coefs a={0,-4,4}, b={4,-4,0}, c={0,16,0}; box (0,0)-(4,4); pix_ready=1 -> exactly 15 pixels, x+y<=4, in raster order (0,0),(1,0)..(4,0),(0,1)..(0,4); done 1 cycle after 25 SCAN cycles.
2. Same triangle with CW vertex order (negated coefs) -> the identical 15 pixels in the same order.
3. Scenario 1 with pix_ready toggling 1,0,0,1 repeating -> the same 15 pixels, each held stable while stalled; no drop or duplicate.
4. Box (5,5)-(4,5) -> no pix_valid; done asserts 2 cycles after start; busy low afterwards.
5. Box (790,590)-(900,700) with coefs a={0,0,0}, b={0,0,0}, c={1,1,1} -> exactly 100 pixels, x 790..799 and y 590..599.
6. reset_n low during pixel 7 of scenario 1 -> pix_valid=0 at once, no done; a new start then reproduces all 15 pixels. start pulsed mid-scan -> ignored.
